trace_line_checker: RTL and testbench
=====================================

Name: trace_line_checker

Overview:
- Streaming checker for CPU write-back trace text, one ASCII character per clock.
- Accepts register-write lines "^T@PPPPPPPP: $R <= DDDDDDDD#" and memory-write lines "^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#".
- For each well-formed line, reports the format type, per-field error flags and the captured data value, and keeps running line and error counters.
- Parametrised generation of the fixed-format checker:
  - configurable field widths and legal ranges;
  - time-monotonicity check;
  - resynchronisation on '^' from any state.

Parameters:
- TIME_DIGITS, 4, maximum decimal digits in the timestamp (minimum 1).
- REG_DIGITS, 4, maximum decimal digits in the register number (minimum 1).
- PC_DIGITS, 8, exact number of hex digits in the PC.
- ADDR_DIGITS, 8, exact number of hex digits in the address.
- DATA_DIGITS, 8, exact number of hex digits in the data.
- NUM_REGS, 32, register numbers >= NUM_REGS are errors.
- PC_LO, 32'h0000_3000, lowest legal PC (inclusive).
- PC_HI, 32'h0000_6FFF, highest legal PC (inclusive).
- ADDR_LO, 32'h0000_0000, lowest legal address (inclusive).
- ADDR_HI, 32'h0000_2FFF, highest legal address (inclusive).
- CNT_W, 16, width of the line and error counters.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- char  input  8  ASCII character, sampled every posedge.
- line_valid  output  1  one-cycle pulse: a complete legal line was accepted.
- format_type  output  2  01 = register line, 10 = memory line, 00 when line_valid = 0.
- error_code  output  4  {reg_err, addr_err, pc_err, time_err}; all zero when line_valid = 0.
- data_out  output  4*DATA_DIGITS  data field of the accepted line; holds its value between lines.
- line_count  output  CNT_W  number of accepted lines, saturating.
- err_count  output  CNT_W  number of accepted lines with error_code != 0, saturating.

Behaviour:
- **Reset** (synchronous, active-high; clock clk):
  - all outputs, counters, field accumulators and last_time go to 0;
  - state goes to IDLE;
  - a line in progress is discarded with no report.
- **Decimal/hex classification:** decimal = '0'-'9'; hex = '0'-'9', 'a'-'f', 'A'-'F'.
- **States:** IDLE, TIME, PC, COLON, SP1, REG, ADDR, SP2, LT, EQ, SP3, DATA, DONE.
- **Resync:** in any state, '^' clears the field accumulators and digit counter and enters TIME (expect 1st digit). This includes DONE and mid-field.
- **Illegal character:** any character not allowed by the current state returns to IDLE with no report.
- **Field rules:**
  - IDLE: only '^' leaves.
  - TIME: 1..TIME_DIGITS decimal digits, then '@'. A digit beyond TIME_DIGITS aborts the line.
  - PC: exactly PC_DIGITS hex digits, then ':'. Any other count aborts.
  - SP1: zero or more ' ', then '$' -> REG or '*' -> ADDR.
  - REG: 1..REG_DIGITS decimal digits, then ' ' -> SP2 or '<' -> LT.
  - ADDR: exactly ADDR_DIGITS hex digits, then ' ' -> SP2 or '<' -> LT.
  - SP2: ' '* then '<'.
  - LT: requires '='.
  - SP3: ' '* then the first hex digit.
  - DATA: exactly DATA_DIGITS hex digits, then '#'.
- **Accumulation:**
  - time and reg use value*10 + digit in 32-bit arithmetic; digit limits prevent overflow.
  - pc, addr and data shift left 4 and OR in the nibble.
- **Accept timing:**
  - '#' sampled at edge N; registered outputs are driven from edge N, so line_valid is high for exactly the cycle after edge N.
  - line_valid drops at edge N+1 regardless of char. A '^' at edge N+1 starts the next line, so back-to-back lines are legal.
- **Error bits** are computed from the completed line:
  - time_err = time < last_time.
  - pc_err = pc < PC_LO, or pc > PC_HI, or pc[1:0] != 0.
  - addr_err (memory lines only) = addr < ADDR_LO, or addr > ADDR_HI, or addr[1:0] != 0. Always 0 on register lines.
  - reg_err (register lines only) = reg >= NUM_REGS. Always 0 on memory lines.
- **last_time:** loaded with time on every accepted line, including lines that carry errors. Aborted lines never update it.
- **Counters:**
  - line_count increments on every line_valid pulse.
  - err_count increments when the error_code reported with the pulse is nonzero.
  - Both saturate at all-ones.
- **data_out:** updated only on accept.

Test Plan:
- "^10@00003000: $5 <= 0000abcd#" -> one-cycle line_valid, format 01, error 0000, data_out 0000abcd, line_count 1.
- "^11@00003002: *00003000 <= FFFFFFFF#" -> format 10, error 0110 (pc misaligned, addr above ADDR_HI), err_count 1.
- "^20@00003000: $32<=00000001#" followed by "^15@00003004: $0 <= 00000002#" -> first line error 1000; second line error 0001 (15 < 20).
- "^1@0000300: $1 <= 00000000#" (7-digit PC) -> no line_valid, counters unchanged. Same for a 5-digit time, and for "< =" with a space between '<' and '='.
- "^5@00003^7@00003000: $1 <= 00000001#" -> resync on the second '^': one pulse with time 7, error 0000.
- Reset asserted while in DATA -> outputs 0, no pulse. Then 2^CNT_W + 1 legal lines -> line_count saturates at FFFF.

Source files
------------

// File: rtl/trace_line_checker.sv
// Streaming checker for CPU write-back trace lines, one ASCII character per clock.
// Reports format, field errors and data for each well-formed line; keeps saturating counters.
module trace_line_checker #(
   parameter int unsigned TIME_DIGITS = 4,
   parameter int unsigned REG_DIGITS  = 4,
   parameter int unsigned PC_DIGITS   = 8,
   parameter int unsigned ADDR_DIGITS = 8,
   parameter int unsigned DATA_DIGITS = 8,
   parameter logic [31:0] NUM_REGS    = 32,
   parameter logic [31:0] PC_LO       = 32'h0000_3000,
   parameter logic [31:0] PC_HI       = 32'h0000_6FFF,
   parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI     = 32'h0000_2FFF,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               char,
   output logic                     line_valid,
   output logic [1:0]               format_type,
   output logic [3:0]               error_code,
   output logic [4*DATA_DIGITS-1:0] data_out,
   output logic [CNT_W-1:0]         line_count,
   output logic [CNT_W-1:0]         err_count
);

   localparam int unsigned DW = 4 * DATA_DIGITS;
   localparam logic [7:0] TIME_N = 8'(TIME_DIGITS);
   localparam logic [7:0] REG_N  = 8'(REG_DIGITS);
   localparam logic [7:0] PC_N   = 8'(PC_DIGITS);
   localparam logic [7:0] ADDR_N = 8'(ADDR_DIGITS);
   localparam logic [7:0] DATA_N = 8'(DATA_DIGITS);

   typedef enum logic [3:0] {
      S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_REG, S_ADDR,
      S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_DONE
   } state_t;

   state_t r_state, w_next;

   logic [31:0]   r_time, r_last_time, r_pc, r_addr, r_reg;
   logic [DW-1:0] r_data;
   logic [7:0]    r_cnt;
   logic          r_is_mem;

   logic            r_line_valid;
   logic [1:0]      r_format;
   logic [3:0]      r_err;
   logic [DW-1:0]   r_data_out;
   logic [CNT_W-1:0] r_line_count, r_err_count;

   logic       w_dec, w_hex;
   logic [3:0] w_nib;
   logic       w_clr, w_cnt_clr, w_cnt_inc;
   logic       w_acc_time, w_acc_pc, w_acc_reg, w_acc_addr, w_acc_data;
   logic       w_set_mem, w_set_reg, w_accept;
   logic       w_time_err, w_pc_err, w_addr_err, w_reg_err;
   logic [3:0] w_err;

   assign w_dec = (char >= "0") && (char <= "9");
   assign w_hex = w_dec || ((char >= "a") && (char <= "f")) || ((char >= "A") && (char <= "F"));
   // letters a-f/A-F have low nibble 1..6, so +9 yields 10..15
   assign w_nib = w_dec ? char[3:0] : 4'(char[3:0] + 4'd9);

   // range checks as offset-from-low compares, valid whenever LO <= HI
   assign w_time_err = r_time < r_last_time;
   assign w_pc_err   = ((r_pc - PC_LO) > (PC_HI - PC_LO)) || (r_pc[1:0] != 2'b00);
   assign w_addr_err = r_is_mem &&
                       (((r_addr - ADDR_LO) > (ADDR_HI - ADDR_LO)) || (r_addr[1:0] != 2'b00));
   assign w_reg_err  = !r_is_mem && (r_reg >= NUM_REGS);
   assign w_err      = {w_reg_err, w_addr_err, w_pc_err, w_time_err};

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_clr      = 1'b0;
      w_cnt_clr  = 1'b0;
      w_cnt_inc  = 1'b0;
      w_acc_time = 1'b0;
      w_acc_pc   = 1'b0;
      w_acc_reg  = 1'b0;
      w_acc_addr = 1'b0;
      w_acc_data = 1'b0;
      w_set_mem  = 1'b0;
      w_set_reg  = 1'b0;
      w_accept   = 1'b0;
      if (char == "^") begin
         w_next = S_TIME;
         w_clr  = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: w_next = S_IDLE;
            S_TIME: begin
               if (w_dec && (r_cnt < TIME_N)) begin
                  w_acc_time = 1'b1;
                  w_cnt_inc  = 1'b1;
               end else if ((char == "@") && (r_cnt != 8'd0)) begin
                  w_next    = S_PC;
                  w_cnt_clr = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_PC: begin
               if (w_hex) begin
                  w_acc_pc  = 1'b1;
                  w_cnt_inc = 1'b1;
                  if (r_cnt == PC_N - 8'd1) w_next = S_COLON;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_COLON: w_next = (char == ":") ? S_SP1 : S_IDLE;
            S_SP1: begin
               if (char == " ") begin
                  w_next = S_SP1;
               end else if (char == "$") begin
                  w_next    = S_REG;
                  w_set_reg = 1'b1;
                  w_cnt_clr = 1'b1;
               end else if (char == "*") begin
                  w_next    = S_ADDR;
                  w_set_mem = 1'b1;
                  w_cnt_clr = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_REG: begin
               if (w_dec && (r_cnt < REG_N)) begin
                  w_acc_reg = 1'b1;
                  w_cnt_inc = 1'b1;
               end else if (((char == " ") || (char == "<")) && (r_cnt != 8'd0)) begin
                  w_next    = (char == " ") ? S_SP2 : S_LT;
                  w_cnt_clr = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_ADDR: begin
               if (w_hex && (r_cnt < ADDR_N)) begin
                  w_acc_addr = 1'b1;
                  w_cnt_inc  = 1'b1;
               end else if (((char == " ") || (char == "<")) && (r_cnt == ADDR_N)) begin
                  w_next    = (char == " ") ? S_SP2 : S_LT;
                  w_cnt_clr = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_SP2: begin
               if (char == " ")      w_next = S_SP2;
               else if (char == "<") w_next = S_LT;
               else                  w_next = S_IDLE;
            end
            S_LT: w_next = (char == "=") ? S_EQ : S_IDLE;
            S_EQ, S_SP3: begin
               if (char == " ") begin
                  w_next = S_SP3;
               end else if (w_hex) begin
                  w_next     = S_DATA;
                  w_acc_data = 1'b1;
                  w_cnt_inc  = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_DATA: begin
               if (w_hex && (r_cnt < DATA_N)) begin
                  w_acc_data = 1'b1;
                  w_cnt_inc  = 1'b1;
               end else if ((char == "#") && (r_cnt == DATA_N)) begin
                  w_next   = S_DONE;
                  w_accept = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_clr) begin
         r_time   <= '0;
         r_pc     <= '0;
         r_addr   <= '0;
         r_reg    <= '0;
         r_data   <= '0;
         r_cnt    <= '0;
         r_is_mem <= 1'b0;
      end else begin
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
         if (w_acc_time) r_time <= r_time * 32'd10 + {28'd0, w_nib};
         if (w_acc_reg)  r_reg  <= r_reg * 32'd10 + {28'd0, w_nib};
         if (w_acc_pc)   r_pc   <= {r_pc[27:0], w_nib};
         if (w_acc_addr) r_addr <= {r_addr[27:0], w_nib};
         if (w_acc_data) r_data <= {r_data[DW-5:0], w_nib};
         if (w_set_mem)  r_is_mem <= 1'b1;
         if (w_set_reg)  r_is_mem <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_line_valid <= 1'b0;
         r_format     <= '0;
         r_err        <= '0;
         r_data_out   <= '0;
         r_last_time  <= '0;
         r_line_count <= '0;
         r_err_count  <= '0;
      end else begin
         r_line_valid <= w_accept;
         r_format     <= w_accept ? (r_is_mem ? 2'b10 : 2'b01) : 2'b00;
         r_err        <= w_accept ? w_err : 4'b0000;
         if (w_accept) begin
            r_data_out  <= r_data;
            r_last_time <= r_time;
            if (r_line_count != '1) r_line_count <= r_line_count + 1'b1;
            if ((w_err != 4'b0000) && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
         end
      end
   end

   assign line_valid  = r_line_valid;
   assign format_type = r_format;
   assign error_code  = r_err;
   assign data_out    = r_data_out;
   assign line_count  = r_line_count;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_trace_line_checker.sv
// Scoreboard bench for trace_line_checker: directed lines push expectations, a monitor pops on each pulse.
// Counter width is reduced so saturation is reachable in a short run.
module tb_trace_line_checker;

   localparam int unsigned CW = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  ch = " ";
   logic        line_valid;
   logic [1:0]  format_type;
   logic [3:0]  error_code;
   logic [31:0] data_out;
   logic [CW-1:0] line_count, err_count;

   typedef struct {
      logic [1:0]    fmt;
      logic [3:0]    err;
      logic [31:0]   data;
      logic [CW-1:0] lc;
      logic [CW-1:0] ec;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   trace_line_checker #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .char(ch),
      .line_valid(line_valid), .format_type(format_type), .error_code(error_code),
      .data_out(data_out), .line_count(line_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic expect_line(input logic [1:0] f, input logic [3:0] e, input logic [31:0] d,
                              input int lc, input int ec);
      exp_t x;
      x.fmt = f; x.err = e; x.data = d; x.lc = CW'(lc); x.ec = CW'(ec);
      q.push_back(x);
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         ch = s[i];
      end
   endtask

   task automatic pad(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ch = " ";
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // monitor: everything sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (line_valid) begin
            if (q.size() == 0) begin
               check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
               exp_t x;
               x = q.pop_front();
               check("format_type", {30'd0, format_type}, {30'd0, x.fmt});
               check("error_code", {28'd0, error_code}, {28'd0, x.err});
               check("data_out", data_out, x.data);
               check("line_count", 32'(line_count), 32'(x.lc));
               check("err_count", 32'(err_count), 32'(x.ec));
            end
         end else begin
            check("idle_zero", {26'd0, format_type, error_code}, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      @(negedge clk);
      check("reset_valid", {31'd0, line_valid}, 32'd0);
      check("reset_data", data_out, 32'd0);
      check("reset_lc", 32'(line_count), 32'd0);
      check("reset_ec", 32'(err_count), 32'd0);

      expect_line(2'b01, 4'b0000, 32'h0000abcd, 1, 0);
      send("^10@00003000: $5 <= 0000abcd#");
      pad(3);
      check("data_hold", data_out, 32'h0000abcd);

      expect_line(2'b10, 4'b0110, 32'hFFFFFFFF, 2, 1);
      send("^11@00003002: *00003000 <= FFFFFFFF#");
      pad(2);

      expect_line(2'b01, 4'b1000, 32'h00000001, 3, 2);
      send("^20@00003000: $32<=00000001#");
      expect_line(2'b01, 4'b0001, 32'h00000002, 4, 3);
      send("^15@00003004: $0 <= 00000002#");
      pad(2);

      send("^1@0000300: $1 <= 00000000#");
      pad(1);
      send("^12345@00003000: $1 <= 00000000#");
      pad(1);
      send("^30@00003000: $1 < = 00000000#");
      pad(3);
      check("abort_lc", 32'(line_count), 32'd4);
      check("abort_ec", 32'(err_count), 32'd3);
      check("abort_data", data_out, 32'h00000002);

      send("^40@00003000: $1 <= 0000");
      do_reset();
      send("1234#");
      pad(3);
      check("midreset_data", data_out, 32'd0);
      check("midreset_lc", 32'(line_count), 32'd0);
      check("midreset_ec", 32'(err_count), 32'd0);

      expect_line(2'b01, 4'b0000, 32'h00000001, 1, 0);
      send("^5@00003^7@00003000: $1 <= 00000001#");
      expect_line(2'b10, 4'b0000, 32'h12345678, 2, 0);
      send("^8@00006FFC: *00002FFC <= 12345678#");
      expect_line(2'b01, 4'b0010, 32'h0000beef, 3, 1);
      send("^9@00007000: $31 <= 0000BEEF#");
      pad(2);

      do_reset();
      for (int i = 1; i <= (1 << CW) + 1; i++) begin
         expect_line(2'b01, 4'b0000, 32'h00000001, (i > (1 << CW) - 1) ? (1 << CW) - 1 : i, 0);
         send("^1@00003000: $1 <= 00000001#");
      end
      pad(4);
      check("sat_lc", 32'(line_count), 32'((1 << CW) - 1));
      check("queue_empty", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
